keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Downstream consumer of the slow divider output; scans a 4x4 matrix keypad and emits debounced key events.
- Runs entirely in the fast `clock_in` domain. The slow scan clock is treated as a data input: it is synchronized and edge-detected internally.
- Drives one column at a time and reads the rows. Reports a key only after the same key is seen for DEBOUNCE_SCANS consecutive full frames.

Parameters:
- DEBOUNCE_SCANS, 3, consecutive identical full-matrix frames needed to accept a press, and consecutive non-matching frames needed to accept a release (legal range 1..15).

Ports:
- clock_in  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- scan_clk  in  1  slow scan clock from the divider; its rising edge is one scan step.
- row_in  in  4  raw keypad rows, active-low, asynchronous.
- col_out  out  4  column drive, one-hot active-low.
- key_code  out  4  accepted key index = row*4 + col; holds its value until the next accepted press.
- key_valid  out  1  one `clock_in` pulse per accepted press.
- key_held  out  1  high from acceptance until the release is accepted.

Behaviour:
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0. Column index=0, FSM=IDLE, frame accumulator cleared, debounce count=0.
- Synchronization:
  - scan_clk passes through a 2-FF synchronizer plus a rising-edge detect, giving `step` (a single `clock_in` cycle pulse).
  - row_in passes through a 2-FF synchronizer.
  - scan_clk high and low phases must each be at least 4 `clock_in` cycles.
- On each step:
  - Sample the synchronized rows for the current column (that column has been driven for a full scan_clk period).
  - Then advance the column index 0→1→2→3→0 and update col_out in the same cycle.
- Frame accumulation:
  - A row bit that is low records a hit with code = row*4 + col.
  - If the frame has several hits, the lowest code wins. No ghost or multi-key flag is reported.
  - The frame completes on the step that samples column 3. Its result is either NONE or a code. The accumulator then clears for the next frame.
- Debounce FSM is evaluated only on frame completion:
  - IDLE:
    - code c → candidate=c, cnt=1, go to CONFIRM.
    - If DEBOUNCE_SCANS==1, accept immediately instead.
  - CONFIRM:
    - same c → cnt++. When cnt reaches DEBOUNCE_SCANS: accept, i.e. key_code=candidate, key_valid=1 for one cycle, key_held=1, go to HELD.
    - different code → candidate=new code, cnt=1.
    - NONE → go to IDLE.
  - HELD:
    - frame == candidate → stay.
    - anything else → cnt=1, go to RELEASE. If DEBOUNCE_SCANS==1, release immediately.
  - RELEASE:
    - frame == candidate → go back to HELD, no pulse.
    - other → cnt++. When cnt reaches DEBOUNCE_SCANS: key_held=0, go to IDLE.
    - A different key pressed while releasing counts as "other"; it is not accepted until the FSM is in IDLE.
- Latency: key_valid and key_held change in the `clock_in` cycle after the step that completes the qualifying frame.
- key_valid never stays high for more than one cycle; at most one pulse per press.
- Reset mid-operation: everything returns to reset values on the next `clock_in` edge. A partial frame is discarded and no pulse is generated.
- cnt is 4 bits wide and saturates at DEBOUNCE_SCANS.

Decomposition:
- Package keypad_pkg:
  - ROWS=4, COLS=4.
  - Key code width = 4.
  - FSM state encoding: IDLE, CONFIRM, HELD, RELEASE.
  - Column reset pattern COL_IDLE=4'b1110.
- Sub-module scan_strobe_sync: 2-FF synchronizer plus rising-edge detector producing `step`. Reuse it for any other slow-strobe consumer.
- The row synchronizer stays inline.

Test Plan (DEBOUNCE_SCANS=3, scan_clk = `clock_in`/20):
- Reset held 3 cycles → col_out=4'b1110, key_code=0, key_valid=0, key_held=0. Release reset, apply 4 scan_clk rises → col_out sequence 1101, 1011, 0111, 1110.
- Press row2/col1 (row_in=4'b1011 while col_out=4'b1101) stable for 5 frames → one key_valid pulse, one cycle wide, after the 3rd frame completes; key_code=9; key_held=1; no further pulses.
- Bounce on key 6: present 2 frames, absent 1, present 3 → exactly one key_valid, at the end of the 6th frame; key_code=6.
- Hold key 9, then none for 2 frames, then key 9 again → key_held stays 1, no new pulse. Then none for 3 frames → key_held=0, key_code still 9.
- Keys 5 and 10 pressed together for 3 frames → key_code=5, single pulse.
- Key 3 present for 2 frames, reset asserted mid-frame, key kept pressed → no pulse before reset. After reset: col_out=4'b1110, and the first pulse arrives only after 3 fresh complete frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes are row*4 + col; the column drive is one-hot active-low.
package keypad_pkg;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [COLS-1:0] COL_IDLE = 4'b1110;

    function automatic code_t make_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/scan_strobe_sync.sv
// Brings a slow strobe into the local clock domain and emits a one-cycle
// pulse on each of its rising edges.
module scan_strobe_sync (
    input  logic clk,
    input  logic srst,
    input  logic strobe_i,
    output logic step_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= strobe_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign step_o = sync_q & ~prev_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns on each scan step, reduces a
// full frame to its lowest pressed code, and debounces press and release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              scan_clk,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic            step;
    logic [ROWS-1:0] rows_meta_q;
    logic [ROWS-1:0] rows_sync_q;
    logic [1:0]      col_idx_q;
    logic [1:0]      col_idx_next;
    logic [COLS-1:0] col_out_q;
    logic            acc_hit_q;
    code_t           acc_code_q;
    logic            col_hit;
    logic [1:0]      col_row;
    code_t           col_code;
    logic            merged_hit;
    code_t           merged_code;
    logic            frame_done;

    state_t     state_q, state_d;
    code_t      cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       accept;
    code_t      code_q, code_d;
    logic       valid_q, valid_d;

    scan_strobe_sync u_step_sync (
        .clk      (clock_in),
        .srst     (reset),
        .strobe_i (scan_clk),
        .step_o   (step)
    );

    // Lowest pressed row in the column currently being sampled.
    always_comb begin
        col_hit = 1'b0;
        col_row = 2'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!rows_sync_q[r]) begin
                col_hit = 1'b1;
                col_row = r[1:0];
            end
        end
    end

    assign col_code     = make_code(col_row, col_idx_q);
    assign merged_hit   = acc_hit_q | col_hit;
    assign merged_code  = (col_hit && (!acc_hit_q || (col_code < acc_code_q))) ? col_code : acc_code_q;
    assign frame_done   = step && (col_idx_q == 2'd3);
    assign col_idx_next = col_idx_q + 2'd1;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            rows_meta_q <= '1;
            rows_sync_q <= '1;
            col_idx_q   <= 2'd0;
            col_out_q   <= COL_IDLE;
            acc_hit_q   <= 1'b0;
            acc_code_q  <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            rows_meta_q <= row_in;
            rows_sync_q <= rows_meta_q;
            code_q      <= code_d;
            valid_q     <= valid_d;
            if (step) begin
                col_idx_q <= col_idx_next;
                col_out_q <= ~(4'b0001 << col_idx_next);
                if (frame_done) begin
                    acc_hit_q  <= 1'b0;
                    acc_code_q <= '0;
                end else begin
                    acc_hit_q  <= merged_hit;
                    acc_code_q <= merged_code;
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;

    // Debounce decisions are taken only on the step that closes a frame.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (frame_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (merged_hit) begin
                        cand_d = merged_code;
                        cnt_d  = 4'd1;
                        if (DEB == 4'd1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (!merged_hit) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else if (merged_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        cand_d = merged_code;
                        cnt_d  = 4'd1;
                    end
                end
                ST_HELD: begin
                    if (!(merged_hit && (merged_code == cand_q))) begin
                        if (DEB == 4'd1) begin
                            cnt_d   = 4'd0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = ST_RELEASE;
                        end
                    end
                end
                default: begin
                    if (merged_hit && (merged_code == cand_q)) begin
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB) begin
                            cnt_d   = 4'd0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        valid_d  = accept;
        code_d   = accept ? cand_d : code_q;
        key_held = (state_q == ST_HELD) || (state_q == ST_RELEASE);
    end

    assign col_out   = col_out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner with a frame-level behavioural model
// and a per-cycle compare process.
module tb_keypad_scanner;
    localparam int N = 3;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       scan_clk = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    always #5 clock_in = ~clock_in;

    keypad_scanner #(.DEBOUNCE_SCANS(N)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .scan_clk  (scan_clk),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Physical keypad: a pressed key shorts its row to its column.
    logic [15:0] keys = '0;
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
    end

    int total = 0;
    int bad = 0;
    int dut_pulses = 0;
    int exp_pulses = 0;
    logic chk_en = 1'b0;

    int         m_col, m_step, m_run_key, m_run_len, m_miss;
    logic       m_held;
    logic [3:0] exp_col, exp_code;
    logic       exp_valid, exp_held;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clock_in) begin
        if (chk_en) begin
            chk("col_out", col_out, exp_col);
            chk("key_code", key_code, exp_code);
            chk("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
            chk("key_held", {3'b000, key_held}, {3'b000, exp_held});
            if (key_valid) dut_pulses++;
        end
    end

    function automatic int lowest_key(input logic [15:0] k);
        for (int i = 0; i < 16; i++)
            if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_col = 0; m_step = 0; m_run_key = 0; m_run_len = 0; m_miss = 0;
        m_held = 1'b0;
        exp_col = 4'b1110; exp_code = 4'd0; exp_valid = 1'b0; exp_held = 1'b0;
    endtask

    // Press: N consecutive frames showing the same key while not held.
    // Release: N consecutive frames not showing the held key.
    task automatic frame_eval(input int f);
        if (!m_held) begin
            if (f < 0) m_run_len = 0;
            else if (m_run_len > 0 && f == m_run_key) m_run_len++;
            else begin
                m_run_key = f;
                m_run_len = 1;
            end
            if (m_run_len >= N) begin
                m_held = 1'b1;
                exp_code = m_run_key[3:0];
                exp_valid = 1'b1;
                m_miss = 0;
                m_run_len = 0;
                exp_pulses++;
            end
        end else begin
            if (f == int'(exp_code)) m_miss = 0;
            else begin
                m_miss++;
                if (m_miss >= N) begin
                    m_held = 1'b0;
                    m_run_len = 0;
                end
            end
        end
        exp_held = m_held;
    endtask

    task automatic model_step();
        logic [3:0] one;
        one = 4'b0001;
        m_col = (m_col + 1) % 4;
        exp_col = ~(one << m_col);
        m_step++;
        if (m_step == 4) begin
            m_step = 0;
            frame_eval(lowest_key(keys));
        end
    endtask

    // One scan_clk period; the DUT reacts on the third clock edge after the rise.
    task automatic do_step();
        @(posedge clock_in); #1 scan_clk = 1'b1;
        repeat (3) @(posedge clock_in);
        #1 model_step();
        @(posedge clock_in); #1 exp_valid = 1'b0;
        repeat (5) @(posedge clock_in);
        #1 scan_clk = 1'b0;
        repeat (10) @(posedge clock_in);
    endtask

    task automatic do_frame(input logic [15:0] k);
        keys = k;
        repeat (4) do_step();
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge clock_in); #1 reset = 1'b1;
        repeat (3) @(posedge clock_in);
        #1 reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    function automatic logic [15:0] bit_of(input int k);
        logic [15:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        int p0;
        int r;
        logic [15:0] rk;

        model_reset();
        repeat (3) @(posedge clock_in);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_col", col_out, 4'b1110);
        chk("rst_code", key_code, 4'd0);
        chk("rst_valid", {3'b000, key_valid}, 4'd0);
        chk("rst_held", {3'b000, key_held}, 4'd0);

        keys = '0;
        do_step(); chk("col_seq1", col_out, 4'b1101);
        do_step(); chk("col_seq2", col_out, 4'b1011);
        do_step(); chk("col_seq3", col_out, 4'b0111);
        do_step(); chk("col_seq4", col_out, 4'b1110);

        // Key 9 held for 5 frames: one pulse after the third.
        p0 = dut_pulses;
        repeat (2) do_frame(bit_of(9));
        chk_int("k9_no_early_pulse", dut_pulses - p0, 0);
        do_frame(bit_of(9));
        chk_int("k9_pulse", dut_pulses - p0, 1);
        repeat (2) do_frame(bit_of(9));
        chk_int("k9_single_pulse", dut_pulses - p0, 1);
        chk("k9_code", key_code, 4'd9);
        chk("k9_model_code", exp_code, 4'd9);
        chk("k9_held", {3'b000, key_held}, 4'd1);

        // Short gap does not release; a full gap does.
        p0 = dut_pulses;
        repeat (2) do_frame('0);
        do_frame(bit_of(9));
        chk("gap_held", {3'b000, key_held}, 4'd1);
        repeat (3) do_frame('0);
        chk("rel_held", {3'b000, key_held}, 4'd0);
        chk("rel_code", key_code, 4'd9);
        chk_int("gap_no_pulse", dut_pulses - p0, 0);

        // Bounce on key 6.
        p0 = dut_pulses;
        repeat (2) do_frame(bit_of(6));
        do_frame('0);
        repeat (2) do_frame(bit_of(6));
        chk_int("k6_no_early_pulse", dut_pulses - p0, 0);
        do_frame(bit_of(6));
        chk_int("k6_pulse", dut_pulses - p0, 1);
        chk("k6_code", key_code, 4'd6);
        repeat (3) do_frame('0);

        // Two keys together: lowest code wins.
        p0 = dut_pulses;
        repeat (3) do_frame(bit_of(5) | bit_of(10));
        chk_int("multi_pulse", dut_pulses - p0, 1);
        chk("multi_code", key_code, 4'd5);
        chk("multi_model_code", exp_code, 4'd5);
        repeat (3) do_frame('0);

        // Randomized frames against the model.
        rk = bit_of(2);
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) rk = '0;
            else if (r == 7) rk = bit_of($urandom_range(0, 15));
            else if (r == 8) rk = bit_of($urandom_range(0, 15)) | bit_of($urandom_range(0, 15));
            else if (r == 9) rk = ($urandom_range(0, 1) != 0) ? bit_of(0) : bit_of(15);
            do_frame(rk);
        end
        chk_int("rand_pulse_count", dut_pulses, exp_pulses);
        repeat (3) do_frame('0);

        // Reset in the middle of a frame discards progress on key 3.
        p0 = dut_pulses;
        repeat (2) do_frame(bit_of(3));
        do_step();
        do_step();
        chk_int("k3_no_pulse_before_rst", dut_pulses - p0, 0);
        do_reset();
        chk("midrst_col", col_out, 4'b1110);
        chk("midrst_held", {3'b000, key_held}, 4'd0);
        chk("midrst_code", key_code, 4'd0);
        p0 = dut_pulses;
        repeat (2) do_frame(bit_of(3));
        chk_int("k3_fresh_no_early", dut_pulses - p0, 0);
        do_frame(bit_of(3));
        chk_int("k3_fresh_pulse", dut_pulses - p0, 1);
        chk("k3_code", key_code, 4'd3);

        chk_int("total_pulses", dut_pulses, exp_pulses);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
